// File: rtl/clock_pkg.sv
// Shared definitions for the BCD timekeeping core.
//   bcd_t       : one packed BCD digit
//   SEC_MAX_H   : seconds tens-digit maximum
//   MIN_MAX_H   : minutes tens-digit maximum
//   HOUR24_MAX  : last hour value in the 24-hour build (packed BCD)
//   HOUR12_MAX  : last hour value in the 12-hour build (packed BCD)
//   DIV_DEFAULT : default clk_1kHz cycles per second tick
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t       SEC_MAX_H   = 4'd5;
    localparam bcd_t       MIN_MAX_H   = 4'd5;
    localparam logic [7:0] HOUR24_MAX  = 8'h23;
    localparam logic [7:0] HOUR12_MAX  = 8'h12;
    localparam int         DIV_DEFAULT = 1000;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD modulo counter used for seconds, minutes and hours.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset (loads RST_VAL)
//   inc             : advance by one
//   clear           : force 00, wins over inc
//   max_val         : last value before wrapping (packed BCD)
//   wrap_val        : value loaded when inc is seen at max_val
//   cnt_h, cnt_l    : tens and units digits (registered)
//   wrap            : combinational carry, high when this inc wraps
import clock_pkg::*;

module bcd_mod_counter #(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clear,
    input  logic [7:0] max_val,
    input  logic [7:0] wrap_val,
    output bcd_t       cnt_h,
    output bcd_t       cnt_l,
    output logic       wrap
);

    bcd_t cnt_h_q, cnt_h_d;
    bcd_t cnt_l_q, cnt_l_d;
    logic at_max;

    assign at_max = ({cnt_h_q, cnt_l_q} == max_val);
    assign wrap   = inc && !clear && at_max;

    always_comb begin
        cnt_h_d = cnt_h_q;
        cnt_l_d = cnt_l_q;
        if (clear) begin
            cnt_h_d = 4'd0;
            cnt_l_d = 4'd0;
        end else if (inc) begin
            if (at_max) begin
                cnt_h_d = wrap_val[7:4];
                cnt_l_d = wrap_val[3:0];
            end else if (cnt_l_q == 4'd9) begin
                cnt_h_d = cnt_h_q + 4'd1;
                cnt_l_d = 4'd0;
            end else begin
                cnt_l_d = cnt_l_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_h_q <= RST_VAL[7:4];
            cnt_l_q <= RST_VAL[3:0];
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_l_q <= cnt_l_d;
        end
    end

    assign cnt_h = cnt_h_q;
    assign cnt_l = cnt_l_q;

endmodule

// File: rtl/bcd_time_counter.sv
// Timekeeping core: divides clk_1kHz down to a 1 Hz tick and keeps
// hh:mm:ss as packed BCD digit pairs, with user adjust pulses.
// Build option: HOUR12_EN selects 12-hour mode (12,01..11) with pm flag;
// when undefined hours run 00..23 and pm is tied 0.
// Ports:
//   clk_1kHz, rst_n          : clock, asynchronous active-low reset
//   run_en                   : 1 = prescaler and seconds advance
//   adj_min, adj_hour        : single-cycle +1 pulses (minutes without carry)
//   clr_sec                  : seconds and prescaler to zero, beats the tick
//   h_cnt*, m_cnt*, s_cnt*   : BCD digits (tens H, units L)
//   sec_tick                 : one-cycle pulse coincident with new seconds
//   pm                       : afternoon flag (12-hour build only)
import clock_pkg::*;

module bcd_time_counter #(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic       clk_1kHz,
    input  logic       rst_n,
    input  logic       run_en,
    input  logic       adj_min,
    input  logic       adj_hour,
    input  logic       clr_sec,
    output logic [3:0] h_cntH,
    output logic [3:0] h_cntL,
    output logic [3:0] m_cntH,
    output logic [3:0] m_cntL,
    output logic [3:0] s_cntH,
    output logic [3:0] s_cntL,
    output logic       sec_tick,
    output logic       pm
);

    localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
    localparam logic [7:0]     SEC_MAX  = {SEC_MAX_H, 4'd9};
    localparam logic [7:0]     MIN_MAX  = {MIN_MAX_H, 4'd9};
`ifdef HOUR12_EN
    localparam logic [7:0]     HOUR_MAX  = HOUR12_MAX;
    localparam logic [7:0]     HOUR_WRAP = 8'h01;
    localparam logic [7:0]     HOUR_RST  = 8'h12;
`else
    localparam logic [7:0]     HOUR_MAX  = HOUR24_MAX;
    localparam logic [7:0]     HOUR_WRAP = 8'h00;
    localparam logic [7:0]     HOUR_RST  = 8'h00;
`endif

    logic [PW-1:0] pre_q, pre_d;
    logic          sec_tick_q;
    logic          tick;
    logic          sec_inc;
    logic          sec_wrap;
    logic          min_inc;
    logic          min_wrap;
    logic          hour_inc;
    logic          hour_wrap_unused;

    assign tick = run_en && (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        if (clr_sec) begin
            pre_d = '0;
        end else if (run_en) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
    end

    // clr_sec suppresses the tick, so no seconds advance or minute carry.
    assign sec_inc  = tick && !clr_sec;
    // A coincident adj_min and seconds carry still count as one increment.
    assign min_inc  = sec_wrap || adj_min;
    // min_wrap also fires for a lone adj_min wrap, which must not reach hours.
    assign hour_inc = (min_wrap && sec_wrap) || adj_hour;

    always_ff @(posedge clk_1kHz or negedge rst_n) begin
        if (!rst_n) begin
            pre_q      <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            sec_tick_q <= sec_inc;
        end
    end

    assign sec_tick = sec_tick_q;

    bcd_mod_counter #(.RST_VAL(8'h00)) u_sec (
        .clk      (clk_1kHz),
        .rst_n    (rst_n),
        .inc      (sec_inc),
        .clear    (clr_sec),
        .max_val  (SEC_MAX),
        .wrap_val (8'h00),
        .cnt_h    (s_cntH),
        .cnt_l    (s_cntL),
        .wrap     (sec_wrap)
    );

    bcd_mod_counter #(.RST_VAL(8'h00)) u_min (
        .clk      (clk_1kHz),
        .rst_n    (rst_n),
        .inc      (min_inc),
        .clear    (1'b0),
        .max_val  (MIN_MAX),
        .wrap_val (8'h00),
        .cnt_h    (m_cntH),
        .cnt_l    (m_cntL),
        .wrap     (min_wrap)
    );

    bcd_mod_counter #(.RST_VAL(HOUR_RST)) u_hour (
        .clk      (clk_1kHz),
        .rst_n    (rst_n),
        .inc      (hour_inc),
        .clear    (1'b0),
        .max_val  (HOUR_MAX),
        .wrap_val (HOUR_WRAP),
        .cnt_h    (h_cntH),
        .cnt_l    (h_cntL),
        .wrap     (hour_wrap_unused)
    );

`ifdef HOUR12_EN
    logic pm_q, pm_d;

    // Any hour increment out of 11 lands on 12 and flips the half-day.
    assign pm_d = pm_q ^ (hour_inc && ({h_cntH, h_cntL} == 8'h11));

    always_ff @(posedge clk_1kHz or negedge rst_n) begin
        if (!rst_n) begin
            pm_q <= 1'b0;
        end else begin
            pm_q <= pm_d;
        end
    end

    assign pm = pm_q;
`else
    assign pm = 1'b0;
`endif

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- Timekeeping core of the digital clock: divides the 1 kHz system clock to a 1 Hz tick and maintains hours/minutes/seconds as packed BCD digit pairs.
- Sits directly upstream of the hourly chime/alarm stage, which consumes m_cntH/m_cntL/s_cntH/s_cntL, and of the display mux.
- Provides user time-setting through single-cycle adjust pulses from the debounced key block.

Parameters:
- DIV, 1000, clk_1kHz cycles per second tick. Minimum 2; benches use 4.

Ports:
- clk_1kHz  input  1  system clock, 1 kHz.
- rst_n  input  1  asynchronous, active-low reset.
- run_en  input  1  1 = time advances on the prescaler; 0 = prescaler and seconds frozen.
- adj_min  input  1  single-cycle pulse: minutes +1, no carry into hours.
- adj_hour  input  1  single-cycle pulse: hours +1.
- clr_sec  input  1  single-cycle pulse: seconds := 00, prescaler := 0.
- h_cntH  output  4  hours tens BCD.
- h_cntL  output  4  hours units BCD.
- m_cntH  output  4  minutes tens BCD, 0..5.
- m_cntL  output  4  minutes units BCD.
- s_cntH  output  4  seconds tens BCD, 0..5.
- s_cntL  output  4  seconds units BCD.
- sec_tick  output  1  one-cycle pulse in the cycle the seconds register advances.
- pm  output  1  afternoon flag. Tied 0 unless HOUR12_EN is defined.

Behaviour:
- Reset (async, rst_n=0):
  - Prescaler = 0.
  - All digit outputs = 0, i.e. 00:00:00. In 12-hour build the hours are 12.
  - sec_tick = 0, pm = 0.
- Prescaler:
  - Counts 0..DIV-1 while run_en=1 and holds while run_en=0.
  - At DIV-1 with run_en=1 it wraps to 0. That same cycle sec_tick is registered high for one cycle and the seconds advance. The advance is visible on the outputs the cycle after the edge.
- All outputs are registered. sec_tick is coincident with the new seconds value.
- Seconds:
  - s_cntL counts 0..9 and wraps to 0 with a carry into s_cntH.
  - s_cntH counts 0..5.
  - 59 -> 00 generates a minute carry.
- Minutes: same digit rules as seconds. 59 -> 00 generates an hour carry.
- Hours (24 h): 00..23. 23 -> 00. In the units digit, 09 -> 10 and 19 -> 20 carry into the tens.
- The digit registers never hold a non-BCD value. Tens digits never exceed their maximum.
- adj_min:
  - Minutes +1 with wrap 59 -> 00 and no hour carry.
  - Seconds and prescaler untouched.
  - Honoured regardless of run_en.
- adj_hour: hours +1 with wrap. Honoured regardless of run_en.
- clr_sec:
  - Seconds := 00 and prescaler := 0.
  - Highest priority over the tick in the same cycle. No sec_tick and no minute carry is emitted that cycle.
- Simultaneous events:
  - adj_min in the same cycle as a seconds-59 carry: minutes advance by exactly 1, not 2. The hour carry is taken only if that single increment wraps 59 -> 00.
  - adj_hour together with an hour carry: hours advance by exactly 1.
  - adj_min and adj_hour together: both apply, each by 1.
- Reset mid-count: all state clears immediately, independent of the clock. Counting resumes from 00:00:00 with a fresh prescaler after rst_n deasserts.

Optional Feature:
- HOUR12_EN defined: hours run 12, 01..11, 12.
  - The transition 11 -> 12 toggles pm. It does so from both the time carry and adj_hour.
  - Reset value is 12 with pm = 0.
- HOUR12_EN undefined: 24-hour behaviour as above, and pm is constant 0.
- Minutes, seconds, prescaler and port list are identical in both builds.

Decomposition:
- Shared package clock_pkg holds:
  - BCD digit typedef (4 bits).
  - Constants SEC_MAX_H=5, MIN_MAX_H=5, HOUR24_MAX=8'h23, HOUR12_MAX=8'h12, DIV_DEFAULT=1000.
- One natural sub-module, bcd_mod_counter: a two-digit BCD counter.
  - Inputs: inc, clear, programmable max.
  - Outputs: the digits and a wrap/carry signal.
  - Instantiated for seconds, minutes and hours.
  - The prescaler and the priority logic stay in the top level.

Test Plan (DIV=4):
- Reset then run_en=1 for 4*60 cycles -> exactly 60 sec_tick pulses; outputs read 00:01:00; no intermediate value has s_cntL > 9.
- Preload by adjust to 23:59:58, run 2 ticks -> 23:59:59, then 00:00:00. Hour and minute carries land in the same cycle as the seconds wrap.
- At 00:59:59, pulse adj_min in the exact cycle the tick fires -> 01:00:00, not 01:01:00.
- run_en=0 for 100 cycles at 00:00:07 -> no sec_tick and the value is unchanged; adj_hour still gives 01:00:07.
- Pulse clr_sec in the cycle the prescaler is at 3 with seconds at 59 -> seconds 00, minutes unchanged, no sec_tick.
- HOUR12_EN build: from reset (12, pm=0), 11 adj_hour pulses -> 11, pm=0; 1 more -> 12, pm=1. Assert rst_n low mid-prescale -> immediately 12:00:00, pm=0.
